// File: rtl/control_store_loader_pkg.sv
// Shared control-store geometry and microword bit positions, used by the
// loader and by the DE stage that decodes the looked-up control bits.
package control_store_loader_pkg;

  localparam int CS_DEPTH  = 64;
  localparam int CS_WIDTH  = 23;
  localparam int CS_ADDR_W = 6;

  localparam int SR1_NEEDED    = 0;
  localparam int SR2_NEEDED    = 1;
  localparam int DRMUX         = 2;
  localparam int ADDR1MUX      = 3;
  localparam int ADDR2MUX1     = 4;
  localparam int ADDR2MUX0     = 5;
  localparam int LSHF1         = 6;
  localparam int ADDRESSMUX    = 7;
  localparam int SR2MUX        = 8;
  localparam int ALUK1         = 9;
  localparam int ALUK0         = 10;
  localparam int ALU_RESULTMUX = 11;
  localparam int BR_OP         = 12;
  localparam int UNCOND_OP     = 13;
  localparam int TRAP_OP       = 14;
  localparam int BR_STALL      = 15;
  localparam int DCACHE_EN     = 16;
  localparam int DCACHE_RW     = 17;
  localparam int DATA_SIZE     = 18;
  localparam int DR_VALUEMUX1  = 19;
  localparam int DR_VALUEMUX0  = 20;
  localparam int LD_REG        = 21;
  localparam int LD_CC         = 22;

endpackage

// File: rtl/control_store_loader_if.sv
// Load handshake, DE lookup port and load status of the control-store loader.
interface control_store_loader_if
  import control_store_loader_pkg::*;
#(
  parameter int WIDTH  = CS_WIDTH,
  parameter int ADDR_W = CS_ADDR_W
);

  logic              start;
  logic              abort;
  logic              wr_valid;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] de_addr;
  logic [WIDTH-1:0]  de_cs_bits;
  logic              de_stall;
  logic              busy;
  logic              loaded;
  logic [ADDR_W:0]   wr_count;
  logic [WIDTH-1:0]  checksum;

  modport master (
    output start, abort, wr_valid, wr_data, de_addr,
    input  wr_ready, de_cs_bits, de_stall, busy, loaded, wr_count, checksum
  );

  modport slave (
    input  start, abort, wr_valid, wr_data, de_addr,
    output wr_ready, de_cs_bits, de_stall, busy, loaded, wr_count, checksum
  );

endinterface

// File: rtl/control_store_loader_cs_ram.sv
// Writable control store: one synchronous write port, one combinational read
// port. Contents are not reset; the loader masks them until a load completes.
module cs_ram
  import control_store_loader_pkg::*;
#(
  parameter int DEPTH  = CS_DEPTH,
  parameter int WIDTH  = CS_WIDTH,
  parameter int ADDR_W = CS_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Row write; a same-cycle read of that row still sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/control_store_loader.sv
// Reloads the control store row by row from a valid/ready stream and serves
// DE lookups once a complete, uninterrupted load has finished.
module control_store_loader
  import control_store_loader_pkg::*;
#(
  parameter int DEPTH  = CS_DEPTH,
  parameter int WIDTH  = CS_WIDTH,
  parameter int ADDR_W = CS_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  control_store_loader_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] ptr_r, ptr_s;
  logic [ADDR_W:0]   count_r, count_s;
  logic [WIDTH-1:0]  checksum_r, checksum_s;
  logic              loaded_r, loaded_s;
  logic              we_s;
  logic              last_s;
  logic              usable_s;
  logic [WIDTH-1:0]  rd_data_s;

  // State and load bookkeeping registers; the array itself is never reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      ptr_r      <= {ADDR_W{1'b0}};
      count_r    <= {(ADDR_W+1){1'b0}};
      checksum_r <= {WIDTH{1'b0}};
      loaded_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      count_r    <= count_s;
      checksum_r <= checksum_s;
      loaded_r   <= loaded_s;
    end
  end

  // Next state and transfer decode; abort wins over both start and a transfer.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    count_s    = count_r;
    checksum_s = checksum_r;
    loaded_s   = loaded_r;
    we_s       = 1'b0;
    last_s     = (ptr_r == ADDR_W'(DEPTH - 1));
    case (state_r)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_s    = LOAD;
          ptr_s      = {ADDR_W{1'b0}};
          count_s    = {(ADDR_W+1){1'b0}};
          checksum_s = {WIDTH{1'b0}};
          loaded_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_s  = IDLE;
          loaded_s = 1'b0;
        end else if (bus.wr_valid) begin
          we_s       = 1'b1;
          ptr_s      = ptr_r + ADDR_W'(1);
          count_s    = count_r + (ADDR_W+1)'(1);
          checksum_s = checksum_r ^ bus.wr_data;
          if (last_s) begin
            state_s  = IDLE;
            loaded_s = 1'b1;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  cs_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_cs_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (ptr_r),
    .wdata (bus.wr_data),
    .raddr (bus.de_addr),
    .rdata (rd_data_s)
  );

  assign usable_s       = loaded_r && (state_r == IDLE);
  assign bus.wr_ready   = (state_r == LOAD);
  assign bus.busy       = (state_r == LOAD);
  assign bus.loaded     = loaded_r;
  assign bus.wr_count   = count_r;
  assign bus.checksum   = checksum_r;
  assign bus.de_stall   = !usable_s;
  assign bus.de_cs_bits = usable_s ? rd_data_s : {WIDTH{1'b0}};

endmodule
